// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decoder handshake,
// redirect/halt controls and status flags.
interface fetch_unit_if #(
   parameter int unsigned PC_WIDTH = 8
);
   logic                imem_req;
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_ack;
   logic [7:0]          imem_data;
   logic [7:0]          instr;
   logic                instr_valid;
   logic                instr_ready;
   logic                jump_en;
   logic                call_en;
   logic                ret_en;
   logic [PC_WIDTH-1:0] jump_target;
   logic                halt;
   logic                halted;
   logic                ras_overflow;
   logic                ras_underflow;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr, instr, instr_valid, halted,
             ras_overflow, ras_underflow,
      input  imem_ack, imem_data, instr_ready, jump_en, call_en, ret_en,
             jump_target, halt
   );

   // Memory / decoder side
   modport slave (
      input  imem_req, imem_addr, instr, instr_valid, halted,
             ras_overflow, ras_underflow,
      output imem_ack, imem_data, instr_ready, jump_en, call_en, ret_en,
             jump_target, halt
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches bytes over req/ack, holds them
// in the instruction register and applies jump/call/ret/halt on consume.
// Optional return-address stack enabled by defining FETCH_RAS_EN; without it
// call acts as jump, ret is ignored and the RAS flags read 0.
module fetch_unit #(
   parameter int unsigned PC_WIDTH  = 8,
   parameter int unsigned RAS_DEPTH = 4
) (
   input logic         clk,
   input logic         rst_n,
   fetch_unit_if.master bus
);

   if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("RAS_DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALTED} state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]          instr_q, instr_d;
   logic                valid_q, valid_d;
   logic                req_q, req_d;
   logic                halted_q, halted_d;

`ifdef FETCH_RAS_EN
   localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
   localparam int unsigned SP_W  = IDX_W + 1;

   logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [SP_W-1:0]     sp_q, sp_d;
   logic                push_c;
   logic                ras_full_c, ras_empty_c;
   logic [PC_WIDTH-1:0] ras_top_c;
   logic                ovf_q, ovf_d, unf_q, unf_d;

   assign ras_full_c  = (sp_q == SP_W'(RAS_DEPTH));
   assign ras_empty_c = (sp_q == '0);
   assign ras_top_c   = ras_q[IDX_W'(sp_q - SP_W'(1))];

   // Stack storage; only the occupied entries are ever read
   always_ff @(posedge clk) begin
      if (push_c) ras_q[IDX_W'(sp_q)] <= pc_q;
   end

   // Stack pointer and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
`else
   logic unused_ret_c;
   assign unused_ret_c      = bus.ret_en;
   assign bus.ras_overflow  = 1'b0;
   assign bus.ras_underflow = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         req_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         req_q    <= req_d;
         halted_q <= halted_d;
      end
   end

   // Next-state: fetch on ack, then resolve the redirect on consume
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
`ifdef FETCH_RAS_EN
      push_c  = 1'b0;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
`endif
      case (state_q)
         S_FETCH: begin
            // ack is honoured only once the request is actually on the bus
            if (req_q && bus.imem_ack) begin
               instr_d = bus.imem_data;
               valid_d = 1'b1;
               pc_d    = pc_q + PC_WIDTH'(1);
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (valid_q && bus.instr_ready) begin
               valid_d = 1'b0;
               state_d = S_FETCH;
               if (bus.halt) begin
                  state_d = S_HALTED;
`ifdef FETCH_RAS_EN
               end else if (bus.ret_en) begin
                  if (!ras_empty_c) begin
                     pc_d = ras_top_c;
                     sp_d = sp_q - SP_W'(1);
                  end else begin
                     unf_d = 1'b1;
                  end
               end else if (bus.call_en) begin
                  // PC already points past the call, so it is the return address
                  if (!ras_full_c) begin
                     push_c = 1'b1;
                     sp_d   = sp_q + SP_W'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
                  pc_d = bus.jump_target;
               end else if (bus.jump_en) begin
                  pc_d = bus.jump_target;
               end
`else
               end else if (bus.call_en || bus.jump_en) begin
                  pc_d = bus.jump_target;
               end
`endif
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
      req_d    = (state_d == S_FETCH);
      halted_d = (state_d == S_HALTED);
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expectations follow the
// FETCH_RAS_EN setting of the build.
module tb_fetch_unit;

`ifdef FETCH_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;

   fetch_unit_if #(.PC_WIDTH(8)) bus ();

   fetch_unit #(.PC_WIDTH(8), .RAS_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.imem_ack    = 1'b0;
      bus.imem_data   = 8'h00;
      bus.instr_ready = 1'b0;
      bus.jump_en     = 1'b0;
      bus.call_en     = 1'b0;
      bus.ret_en      = 1'b0;
      bus.jump_target = 8'h00;
      bus.halt        = 1'b0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Wait for a request, hold ack off for 'delay' cycles, then return 'data'
   task automatic do_fetch(input int delay, input logic [7:0] data,
                           output logic [7:0] addr, output bit got,
                           output int req_cycles);
      int n = 0;
      got = 1'b0;
      addr = 8'h00;
      req_cycles = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.imem_req === 1'b1) begin
         got  = 1'b1;
         addr = bus.imem_addr;
         for (int i = 0; i < delay; i++) begin
            if (bus.imem_req === 1'b1) req_cycles++;
            @(negedge clk);
         end
         bus.imem_ack  = 1'b1;
         bus.imem_data = data;
         @(negedge clk);
         bus.imem_ack  = 1'b0;
      end
   endtask

   task automatic consume(input bit h, input bit r, input bit c, input bit j,
                          input logic [7:0] tgt);
      bus.instr_ready = 1'b1;
      bus.halt        = h;
      bus.ret_en      = r;
      bus.call_en     = c;
      bus.jump_en     = j;
      bus.jump_target = tgt;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else passes++;
      checks++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.instr_valid); else passes++;
      checks++; if (bus.instr !== 8'h00) $display("FAIL reset_instr: got %h want 00", bus.instr); else passes++;
      checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", bus.halted); else passes++;
      checks++; if (bus.imem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", bus.imem_addr); else passes++;
      checks++; if (bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0)
         $display("FAIL reset_flags: got %b%b want 00", bus.ras_overflow, bus.ras_underflow); else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (bus.imem_req !== 1'b0) $display("FAIL release_req_low: got %b want 0", bus.imem_req); else passes++;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1) $display("FAIL release_req_high: got %b want 1", bus.imem_req); else passes++;
   endtask

   task automatic test_sequential();
      logic [7:0] d [3] = '{8'h11, 8'h22, 8'h33};
      logic [7:0] a;
      bit got;
      int rc;
      reset_dut();
      for (int k = 0; k < 3; k++) begin
         do_fetch(0, d[k], a, got, rc);
         checks++; if (got !== 1'b1 || a !== 8'(k)) $display("FAIL seq_addr%0d: got %h (req %b) want %h", k, a, got, 8'(k)); else passes++;
         checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== d[k])
            $display("FAIL seq_instr%0d: got %h valid %b want %h valid 1", k, bus.instr, bus.instr_valid, d[k]); else passes++;
         consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1)
            $display("FAIL seq_gap%0d: got valid %b req %b want valid 0 req 1", k, bus.instr_valid, bus.imem_req); else passes++;
      end
   endtask

   task automatic test_wait_states();
      logic [7:0] a;
      bit got;
      int rc;
      reset_dut();
      do_fetch(3, 8'h11, a, got, rc);
      checks++; if (got !== 1'b1 || rc !== 3) $display("FAIL wait_req_cycles: got %0d want 3", rc); else passes++;
      checks++; if (a !== 8'h00) $display("FAIL wait_addr: got %h want 00", a); else passes++;
      for (int i = 0; i < 2; i++) begin
         checks++; if (bus.instr !== 8'h11 || bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0)
            $display("FAIL wait_hold%0d: got instr %h valid %b req %b want 11 1 0", i, bus.instr, bus.instr_valid, bus.imem_req); else passes++;
         @(negedge clk);
      end
      consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      do_fetch(0, 8'hAA, a, got, rc);
      checks++; if (got !== 1'b1 || a !== 8'h01) $display("FAIL wait_next_pc: got %h want 01", a); else passes++;
      consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_call_ret();
      logic [7:0] a;
      bit got;
      int rc;
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         do_fetch(0, 8'h00, a, got, rc);
         consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      do_fetch(0, 8'hC0, a, got, rc);
      checks++; if (got !== 1'b1 || a !== 8'h05) $display("FAIL call_site: got %h want 05", a); else passes++;
      consume(1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
      do_fetch(0, 8'hE0, a, got, rc);
      checks++; if (got !== 1'b1 || a !== 8'h40) $display("FAIL call_target: got %h want 40", a); else passes++;
      consume(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      do_fetch(0, 8'h00, a, got, rc);
      checks++; if (got !== 1'b1 || a !== (RAS_ON ? 8'h06 : 8'h41))
         $display("FAIL ret_target: got %h want %h", a, RAS_ON ? 8'h06 : 8'h41); else passes++;
      consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_ras_limits();
      logic [7:0] call_at [5] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
      logic [7:0] ret_ras [5] = '{8'h31, 8'h21, 8'h11, 8'h01, 8'h02};
      logic [7:0] ret_seq [5] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
      logic [7:0] a, cur;
      bit got;
      int rc;
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         do_fetch(0, 8'hC0, a, got, rc);
         checks++; if (got !== 1'b1 || a !== call_at[i]) $display("FAIL nest_call%0d: got %h want %h", i, a, call_at[i]); else passes++;
         consume(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 * (i + 1)));
         if (i == 3) begin
            checks++; if (bus.ras_overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", bus.ras_overflow); else passes++;
         end
      end
      checks++; if (bus.ras_overflow !== RAS_ON) $display("FAIL ovf_set: got %b want %b", bus.ras_overflow, RAS_ON); else passes++;
      cur = 8'h50;
      for (int i = 0; i < 5; i++) begin
         do_fetch(0, 8'hE0, a, got, rc);
         checks++; if (got !== 1'b1 || a !== cur) $display("FAIL nest_ret%0d: got %h want %h", i, a, cur); else passes++;
         if (i == 4) begin
            checks++; if (bus.ras_underflow !== 1'b0) $display("FAIL unf_early: got %b want 0", bus.ras_underflow); else passes++;
         end
         consume(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         cur = RAS_ON ? ret_ras[i] : ret_seq[i];
      end
      do_fetch(0, 8'h00, a, got, rc);
      checks++; if (got !== 1'b1 || a !== cur) $display("FAIL unf_resume: got %h want %h", a, cur); else passes++;
      checks++; if (bus.ras_underflow !== RAS_ON) $display("FAIL unf_set: got %b want %b", bus.ras_underflow, RAS_ON); else passes++;
      checks++; if (bus.ras_overflow !== RAS_ON) $display("FAIL ovf_sticky: got %b want %b", bus.ras_overflow, RAS_ON); else passes++;
      consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_wrap_halt();
      logic [7:0] a;
      bit got;
      int rc;
      reset_dut();
      do_fetch(0, 8'h01, a, got, rc);
      consume(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
      do_fetch(0, 8'h02, a, got, rc);
      checks++; if (got !== 1'b1 || a !== 8'hFF) $display("FAIL wrap_max: got %h want ff", a); else passes++;
      consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      do_fetch(0, 8'h03, a, got, rc);
      checks++; if (got !== 1'b1 || a !== 8'h00) $display("FAIL wrap_zero: got %h want 00", a); else passes++;
      consume(1'b1, 1'b0, 1'b0, 1'b1, 8'h80);
      checks++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
         $display("FAIL halt_enter: got halted %b req %b valid %b want 1 0 0", bus.halted, bus.imem_req, bus.instr_valid); else passes++;
      checks++; if (bus.imem_addr !== 8'h01) $display("FAIL halt_pc: got %h want 01", bus.imem_addr); else passes++;
      bus.imem_ack = 1'b1;
      bus.imem_data = 8'h99;
      bus.instr_ready = 1'b1;
      repeat (3) @(negedge clk);
      idle_inputs();
      checks++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h01)
         $display("FAIL halt_stay: got halted %b req %b valid %b addr %h want 1 0 0 01",
                  bus.halted, bus.imem_req, bus.instr_valid, bus.imem_addr); else passes++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] a;
      bit got;
      int rc;
      reset_dut();
      do_fetch(0, 8'h5A, a, got, rc);
      consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01)
         $display("FAIL mid_setup: got req %b addr %h want 1 01", bus.imem_req, bus.imem_addr); else passes++;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h00)
         $display("FAIL mid_reset: got req %b valid %b addr %h want 0 0 00", bus.imem_req, bus.instr_valid, bus.imem_addr); else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      do_fetch(0, 8'h77, a, got, rc);
      checks++; if (got !== 1'b1 || a !== 8'h00) $display("FAIL mid_restart: got %h want 00", a); else passes++;
      checks++; if (bus.instr !== 8'h77 || bus.instr_valid !== 1'b1)
         $display("FAIL mid_instr: got %h valid %b want 77 1", bus.instr, bus.instr_valid); else passes++;
      consume(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_sequential();
      test_wait_states();
      test_call_ret();
      test_ras_limits();
      test_wrap_halt();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter (PC) and requests 8-bit instruction bytes from instruction memory over a req/ack handshake.
- Holds each fetched byte in an instruction register and presents it to decode/execute with a valid/ready handshake.
- Applies PC redirects (jump, call, ret) and halt, using an internal return-address stack (RAS).

Parameters:
- PC_WIDTH, 8, width of the PC and of instruction memory addresses.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, at least 2).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_WIDTH  fetch address; always equals the PC.
- imem_ack  in  1  memory has returned data on imem_data this cycle.
- imem_data  in  8  instruction byte returned by memory.
- instr  out  8  instruction register, to the decoder.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  downstream consumes instr this cycle.
- jump_en  in  1  redirect to jump_target; sampled only on consume.
- call_en  in  1  push return address, then redirect to jump_target; sampled only on consume.
- ret_en  in  1  redirect to the popped return address; sampled only on consume.
- jump_target  in  PC_WIDTH  redirect target for jump and call.
- halt  in  1  stop fetching; sampled only on consume.
- halted  out  1  block is in HALTED.
- ras_overflow  out  1  sticky; a call occurred while the RAS was full.
- ras_underflow  out  1  sticky; a ret occurred while the RAS was empty.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-transaction): state=FETCH, PC=0, instr=0, instr_valid=0, imem_req=0, halted=0, RAS empty, both sticky flags 0. imem_req is 0 while rst_n is low and rises in the first cycle after reset is released.
- State FETCH:
  - imem_req=1, imem_addr=PC.
  - Wait any number of cycles for imem_ack.
  - On imem_ack: instr<=imem_data, instr_valid<=1, PC<=PC+1 (modulo 2^PC_WIDTH, so max wraps to 0), go to HOLD.
  - Minimum latency is 1 cycle from request to instr_valid.
- State HOLD:
  - imem_req=0; instr is stable.
  - Consume event = instr_valid && instr_ready. Without a consume, hold indefinitely.
  - On consume, instr_valid<=0 and exactly one action is taken, in this priority order: halt, then ret_en, then call_en, then jump_en, then sequential.
  - halt: go to HALTED; PC is unchanged.
  - ret_en: if the RAS is non-empty, PC<=top entry and pop. If empty, PC is unchanged (sequential) and ras_underflow<=1.
  - call_en: if the RAS is not full, push PC, which already equals the call address+1. If full, do not push and set ras_overflow<=1. PC<=jump_target in both cases.
  - jump_en: PC<=jump_target.
  - sequential: PC unchanged.
  - Every non-halt action returns to FETCH on the next cycle.
- State HALTED: imem_req=0, halted=1, instr_valid=0. Exit only through reset.
- Redirect inputs are ignored outside a consume cycle, so no wrong-path fetch ever occurs and no flush is needed.
- ras_overflow and ras_underflow clear only on reset.
- imem_ack is ignored outside FETCH.

Optional Feature:
- Macro: FETCH_RAS_EN.
- Defined: full RAS behaviour as described above.
- Not defined:
  - No stack storage is built.
  - call_en behaves exactly like jump_en.
  - ret_en is ignored, so PC stays sequential.
  - ras_overflow and ras_underflow are tied to 0.

Test Plan:
- Reset release, memory acks every cycle with bytes 0x11,0x22,0x33, instr_ready=1 -> imem_addr sequence 0,1,2; instr 0x11,0x22,0x33, each valid for one cycle and separated by a FETCH cycle.
- Ack delayed 3 cycles and instr_ready low for 2 cycles -> imem_req held high for 3 cycles; instr stays 0x11 with instr_valid=1 until consumed; PC=1 afterwards.
- At PC=5 consume with call_en=1, jump_target=0x40; later consume with ret_en=1 -> fetches 0x40, then resumes at 0x06.
- Five nested calls with RAS_DEPTH=4, then five rets -> ras_overflow=1 after the 5th call; the first four rets pop in LIFO order; the 5th ret sets ras_underflow=1 and continues sequentially.
- PC=0xFF with sequential consume -> next imem_addr=0x00; consume with halt=1 and jump_en=1 -> halted=1, imem_req stays 0, PC unchanged.
- rst_n pulsed low while imem_req=1 and no ack yet -> imem_req drops immediately, instr_valid=0, and fetch restarts at address 0.
